// File: rtl/hps_adapter_util_pkg.sv
// Shared constants and helpers for the HPS adapter utility blocks.
package hps_adapter_util_pkg;

  localparam string FAMILY_AGILEX = "Agilex";
  localparam string FAMILY_S10    = "S10";
  localparam string FAMILY_OTHER  = "Other";

  // Memory depth for a given address width, without relying on $clog2.
  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/hps_adapter_util_generic_mlab_sc.sv
// Single-clock simple dual-port memory with a registered read port.
module hps_adapter_util_generic_mlab_sc
  import hps_adapter_util_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter string       FAMILY     = "Other"
) (
  input  logic                  clk,
  input  logic                  aclr_n,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);

  localparam int unsigned DEPTH   = depth_of(ADDR_WIDTH);
  localparam bit          IS_HARD = (FAMILY == FAMILY_AGILEX) || (FAMILY == FAMILY_S10);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage array; contents are never reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  generate
    if (IS_HARD) begin : g_hard_rd
      // Hard MLAB output register has no clear.
      always_ff @(posedge clk) begin
        if (re_i) begin
          rdata_q <= mem_q[raddr_i];
        end
      end
    end else begin : g_soft_rd
      // Generic output register, cleared with the rest of the block.
      always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
          rdata_q <= '0;
        end else if (re_i) begin
          rdata_q <= mem_q[raddr_i];
        end
      end
    end
  endgenerate

  assign rdata_o = rdata_q;

endmodule

// File: rtl/hps_adapter_util_ostage2.sv
// Two-entry register FIFO that holds the show-ahead output stage.
module hps_adapter_util_ostage2
  import hps_adapter_util_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic [1:0]       cnt_o
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             valid_q, valid_d;

  // Next-state: the caller never loads a full stage without popping it.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    if (load_i && pop_i) begin
      if (cnt_q == 2'd2) begin
        head_d = tail_q;
        tail_d = data_i;
      end else begin
        head_d = data_i;
      end
    end else if (load_i) begin
      if (cnt_q == 2'd0) begin
        head_d = data_i;
      end else begin
        tail_d = data_i;
      end
      cnt_d = cnt_q + 2'd1;
    end else if (pop_i) begin
      head_d = tail_q;
      cnt_d  = cnt_q - 2'd1;
    end
    valid_d = (cnt_d != 2'd0);
  end

  // Stage registers.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = head_q;
  assign valid_o = valid_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/hps_adapter_util_sc_fifo.sv
// Single-clock show-ahead FIFO: MLAB storage plus a 2-entry output stage.
module hps_adapter_util_sc_fifo
  import hps_adapter_util_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter string       FAMILY     = "Other"
) (
  input  logic                  clk,
  input  logic                  aclr_n,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH+1:0] used_words
);

  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);
  localparam int unsigned PW    = ADDR_WIDTH + 1;
  localparam int unsigned UW    = ADDR_WIDTH + 2;

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic             inflight_q, inflight_d;
  logic [UW-1:0]    used_q, used_d;
  logic             in_ready_q, in_ready_d;

  logic             push_c;
  logic             pop_c;
  logic             re_c;
  logic [PW-1:0]    occ_c;
  logic [PW-1:0]    occ_next_c;
  logic [1:0]       ostage_cnt;
  logic [WIDTH-1:0] mem_rdata;

  // Handshakes, read issue and pointer/count next-state.
  always_comb begin
    push_c     = in_valid & in_ready_q;
    pop_c      = out_valid & out_ready;
    occ_c      = wptr_q - rptr_q;
    re_c       = (occ_c != '0) &&
                 (({1'b0, ostage_cnt} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop_c}));
    wptr_d     = wptr_q + PW'(push_c);
    rptr_d     = rptr_q + PW'(re_c);
    inflight_d = re_c;
    used_d     = used_q + UW'(push_c) - UW'(pop_c);
    occ_next_c = wptr_d - rptr_d;
    in_ready_d = (occ_next_c != PW'(DEPTH));
  end

  // Pointer, in-flight, occupancy and ready registers.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      inflight_q <= 1'b0;
      used_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      inflight_q <= inflight_d;
      used_q     <= used_d;
      in_ready_q <= in_ready_d;
    end
  end

  hps_adapter_util_generic_mlab_sc #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .FAMILY     (FAMILY)
  ) u_mlab (
    .clk     (clk),
    .aclr_n  (aclr_n),
    .we_i    (push_c),
    .waddr_i (wptr_q[ADDR_WIDTH-1:0]),
    .wdata_i (in_data),
    .re_i    (re_c),
    .raddr_i (rptr_q[ADDR_WIDTH-1:0]),
    .rdata_o (mem_rdata)
  );

  hps_adapter_util_ostage2 #(
    .WIDTH (WIDTH)
  ) u_ostage (
    .clk     (clk),
    .aclr_n  (aclr_n),
    .load_i  (inflight_q),
    .data_i  (mem_rdata),
    .pop_i   (pop_c),
    .data_o  (out_data),
    .valid_o (out_valid),
    .cnt_o   (ostage_cnt)
  );

  assign in_ready   = in_ready_q;
  assign used_words = used_q;

endmodule

// File: tb/tb_hps_adapter_util_sc_fifo.sv
// Directed and randomized checks for the show-ahead single-clock FIFO.
module tb_hps_adapter_util_sc_fifo;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned ADDR_WIDTH = 5;

  logic                  clk;
  logic                  aclr_n;
  logic [WIDTH-1:0]      in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH+1:0] used_words;

  int total;
  int bad;

  hps_adapter_util_sc_fifo #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .FAMILY     ("Other")
  ) dut (
    .clk        (clk),
    .aclr_n     (aclr_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .used_words (used_words)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pop n words with out_ready held high, expecting base, base+1, ...
  task automatic drain(input int base, input int n, input string tag);
    int got;
    got       = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 200 && got < n; i++) begin
      if (out_valid) begin
        chk(tag, 32'(out_data), 32'((base + got) & 8'hFF));
        got++;
      end
      tick();
    end
    out_ready = 1'b0;
    chk({tag, "_count"}, 32'(got), 32'(n));
  endtask

  // Push n consecutive values starting at base, one per cycle, no pops.
  task automatic push_run(input int base, input int n);
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = 8'((base + i) & 8'hFF);
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int exp_n;
    int gaps;
    int prev_stall;
    logic [WIDTH-1:0] prev_data;
    logic [WIDTH-1:0] q[$];
    logic do_push;
    logic do_pop;

    total     = 0;
    bad       = 0;
    aclr_n    = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state.
    #1 aclr_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_used", 32'(used_words), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    aclr_n = 1'b1;
    tick();
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Single push, 2-cycle latency.
    in_valid = 1'b1;
    in_data  = 8'hA5;
    tick();
    in_valid = 1'b0;
    chk("one_used_e0", 32'(used_words), 32'd1);
    chk("one_valid_e0", 32'(out_valid), 32'd0);
    tick();
    chk("one_valid_e1", 32'(out_valid), 32'd0);
    tick();
    chk("one_valid_e2", 32'(out_valid), 32'd1);
    chk("one_data_e2", 32'(out_data), 32'hA5);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("one_pop_valid", 32'(out_valid), 32'd0);
    chk("one_pop_used", 32'(used_words), 32'd0);

    // Fill with no pops; only 34 of 36 pushes fit.
    push_run(0, 36);
    chk("fill_used", 32'(used_words), 32'd34);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    drain(0, 34, "fill_drain");
    repeat (3) tick();
    chk("fill_after_valid", 32'(out_valid), 32'd0);
    chk("fill_after_used", 32'(used_words), 32'd0);
    chk("fill_after_ready", 32'(in_ready), 32'd1);

    // Continuous streaming.
    exp_n = 0;
    gaps  = 0;
    for (int c = 0; c < 200; c++) begin
      if (out_valid) begin
        chk("stream_data", 32'(out_data), 32'(exp_n & 8'hFF));
        exp_n++;
      end else if (c >= 3) begin
        gaps++;
      end
      in_valid  = 1'b1;
      in_data   = 8'(c & 8'hFF);
      out_ready = 1'b1;
      tick();
    end
    chk("stream_gaps", 32'(gaps), 32'd0);
    chk("stream_pops", 32'(exp_n), 32'd197);
    drain(197, 3, "stream_tail");
    chk("stream_used", 32'(used_words), 32'd0);

    // Randomized traffic against a reference queue.
    q.delete();
    prev_stall = 0;
    prev_data  = '0;
    for (int c = 0; c < 10000; c++) begin
      chk("rnd_used", 32'(used_words), 32'(q.size()));
      if (used_words > 34) chk("rnd_used_max", 32'(used_words), 32'd34);
      if (prev_stall != 0 && out_valid) chk("rnd_stable", 32'(out_data), 32'(prev_data));
      in_valid  = 1'($urandom_range(1));
      out_ready = 1'($urandom_range(1));
      in_data   = 8'($urandom_range(255));
      do_push   = in_valid & in_ready;
      do_pop    = out_valid & out_ready;
      if (do_pop) begin
        if (q.size() == 0) begin
          chk("rnd_pop_empty", 32'(q.size()), 32'd1);
        end else begin
          chk("rnd_data", 32'(out_data), 32'(q.pop_front()));
        end
      end
      if (do_push) q.push_back(in_data);
      prev_stall = (out_valid && !out_ready) ? 1 : 0;
      prev_data  = out_data;
      tick();
    end
    drain(0, 0, "rnd_dummy");
    begin
      int n;
      int ok;
      n  = q.size();
      ok = 0;
      out_ready = 1'b1;
      in_valid  = 1'b0;
      for (int i = 0; i < 200 && ok < n; i++) begin
        if (out_valid) begin
          chk("rnd_tail", 32'(out_data), 32'(q.pop_front()));
          ok++;
        end
        tick();
      end
      out_ready = 1'b0;
      chk("rnd_tail_count", 32'(ok), 32'(n));
    end
    chk("rnd_end_used", 32'(used_words), 32'd0);

    // Reset with 20 words buffered and a read in flight.
    push_run(8'h40, 20);
    repeat (3) tick();
    chk("mid_used", 32'(used_words), 32'd20);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("mid_used_pop", 32'(used_words), 32'd19);
    aclr_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_used", 32'(used_words), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    aclr_n = 1'b1;
    tick();
    chk("mid_rel_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("mid_first_valid", 32'(out_valid), 32'd1);
    chk("mid_first_data", 32'(out_data), 32'h5A);
    chk("mid_first_used", 32'(used_words), 32'd1);
    drain(8'h5A, 1, "mid_drain");
    repeat (3) tick();
    chk("mid_end_valid", 32'(out_valid), 32'd0);

    // Illegal pop on empty alongside a legal push.
    in_valid  = 1'b1;
    in_data   = 8'h33;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("edge_pop_empty_used", 32'(used_words), 32'd1);
    repeat (2) tick();
    chk("edge_pop_empty_data", 32'(out_data), 32'h33);
    drain(8'h33, 1, "edge_pe_drain");

    // Illegal push on full alongside a legal pop.
    push_run(8'h80, 34);
    chk("edge_full_used", 32'(used_words), 32'd34);
    chk("edge_full_ready", 32'(in_ready), 32'd0);
    chk("edge_full_head", 32'(out_data), 32'h80);
    in_valid  = 1'b1;
    in_data   = 8'hEE;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("edge_push_full_used", 32'(used_words), 32'd33);
    drain(8'h81, 33, "edge_pf_drain");
    repeat (3) tick();
    chk("edge_pf_end_valid", 32'(out_valid), 32'd0);
    chk("edge_pf_end_used", 32'(used_words), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
